multicore_bus_ctrl: RTL and testbench
=====================================

MULTICORE_BUS_CTRL -- requirements
Module: multicore_bus_ctrl

Interface
REQ-001 Parameter NCPU, default 4, number of cores with an I-cache/D-cache pair (2..8).
REQ-002 Parameter BLOCK_WORDS, default 2, words per cache block (power of two, 1..8).
REQ-003 CLK  in  1  clock, rising edge.
REQ-004 nRST  in  1  reset, asynchronous, active-low.
REQ-005 iREN  in  NCPU  per-core instruction read request.
REQ-006 iaddr  in  NCPUx32  per-core instruction address.
REQ-007 iwait / iload  out  NCPU / NCPUx32  instruction stall, instruction data.
REQ-008 dREN / dWEN  in  NCPU each  per-core data block read (BusRd) / read-exclusive (BusRdX).
REQ-009 daddr / dstore  in  NCPUx32 each  per-core data word address / write data.
REQ-010 dwait / dload  out  NCPU / NCPUx32  data stall, data read data.
REQ-011 ccwrite / cctrans  in  NCPU each  snoop hit-dirty / cache state-transition done.
REQ-012 ccwait / ccinv  out  NCPU each  snoop stall / invalidate command.
REQ-013 ccsnoopaddr  out  NCPUx32  snoop address per core.
REQ-014 ramREN / ramWEN  out  1 each  RAM read / write enable.
REQ-015 ramaddr / ramstore / ramload  out/out/in  32 each  RAM address, write data, read data.
REQ-016 ramstate  in  ramstate_t  FREE, BUSY, ACCESS, ERROR.

Function
REQ-017 States: IDLE, IFETCH, SNOOP, WB, MEM, FIN; all outputs default 0 in every state.
REQ-018 IDLE: any dREN|dWEN wins over any iREN; data grant to first requesting core at or after dptr (round-robin), instruction grant likewise from iptr.
REQ-019 On data grant: req <= winner, dptr <= (winner+1) mod NCPU, next SNOOP; on instruction grant: ireq <= winner, iptr <= (winner+1) mod NCPU, next IFETCH.
REQ-020 IFETCH: ramREN=1, ramaddr=iaddr[ireq], iload[ireq]=ramload, iwait[ireq]=(ramstate!=ACCESS); on ACCESS -> IDLE.
REQ-021 SNOOP (exactly 1 cycle): dwait[req]=1; for every k!=req ccwait[k]=1, ccsnoopaddr[k]=daddr[req], ccinv[k]=dWEN[req].
REQ-022 SNOOP exit: if any k!=req has ccwrite[k], sup <= lowest such index, next WB; else next MEM; beat counter <= 0.
REQ-023 WB: ccwait[sup]=1, ramWEN=1, ramaddr=daddr[sup], ramstore=dstore[sup], dwait[sup]=(ramstate!=ACCESS), dwait[req]=1.
REQ-024 WB: each ACCESS increments beat; ACCESS on beat BLOCK_WORDS-1 -> MEM, beat <= 0.
REQ-025 MEM: ramREN=dREN[req], ramWEN=dWEN[req], ramaddr=daddr[req], ramstore=dstore[req], dload[req]=ramload, dwait[req]=(ramstate!=ACCESS).
REQ-026 MEM: ACCESS increments beat; ACCESS on beat BLOCK_WORDS-1 -> FIN.
REQ-027 FIN: dwait[req]=1; remains until cctrans[req]=1, then IDLE.
REQ-028 ramstate ERROR treated as not-ACCESS (stall, no beat advance).
REQ-029 Requests arriving outside IDLE wait; no grant is preempted; a requester dropping its request mid-transaction does not change state sequence.
REQ-030 Beat counter width clog2(BLOCK_WORDS), min 1; never exceeds BLOCK_WORDS-1.
REQ-031 Fairness: a continuously requesting core is granted within NCPU data transactions.

Reset
REQ-032 nRST low: state=IDLE, dptr=0, iptr=0, req=0, ireq=0, sup=0, beat=0 immediately; all outputs 0.
REQ-033 Reset mid-transaction abandons it; first cycle after release is IDLE.

Verification
REQ-034 NCPU=4, cores 1 and 3 dREN, dptr=0 -> core 1 granted, then core 3; dptr ends 0.
REQ-035 Core 0 iREN and core 2 dREN same cycle -> SNOOP for core 2 first, IFETCH core 0 after FIN.
REQ-036 Core 0 dWEN, core 2 ccwrite=1 in SNOOP -> ccinv=4'b1110, WB 2 ramWEN beats at daddr[2], then MEM 2 beats, FIN until cctrans[0].
REQ-037 Cores 1 and 3 ccwrite together -> sup=1 only; no ramWEN from core 3 data.
REQ-038 ramstate BUSY 3 cycles per beat in MEM -> dwait[req]=1 held, beat advances only on ACCESS; total MEM = 8 cycles for BLOCK_WORDS=2.
REQ-039 nRST asserted in WB beat 1 -> all outputs 0 same cycle, IDLE after release, dptr=0.

Source files
------------

// File: rtl/multicore_bus_ctrl.sv
// multicore_bus_ctrl
//   Arbitrates NCPU I-cache/D-cache pairs onto one RAM port and runs a
//   snoop-based coherence sequence for data block transfers.
//   Data requests (BusRd via dREN, BusRdX via dWEN) win over instruction
//   fetches. Each class has its own round-robin pointer.
//   Data sequence: SNOOP (1 cycle) -> [WB of dirty supplier block] -> MEM -> FIN.
// Ports
//   CLK, nRST                  clock, async active-low reset
//   iREN/iaddr -> iwait/iload  per-core instruction fetch
//   dREN/dWEN/daddr/dstore     per-core data block request
//   dwait/dload                per-core data stall / read data
//   ccwrite/cctrans            snoop hit-dirty / state transition done
//   ccwait/ccinv/ccsnoopaddr   snoop stall / invalidate / snoop address
//   ramREN/ramWEN/ramaddr/ramstore/ramload/ramstate   RAM port
package multicore_bus_ctrl_pkg;
    typedef enum logic [1:0] {FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3} ramstate_t;
endpackage

module multicore_bus_ctrl
    import multicore_bus_ctrl_pkg::*;
#(
    parameter int NCPU        = 4,
    parameter int BLOCK_WORDS = 2
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic [NCPU-1:0]            iREN,
    input  logic [NCPU-1:0][31:0]      iaddr,
    output logic [NCPU-1:0]            iwait,
    output logic [NCPU-1:0][31:0]      iload,
    input  logic [NCPU-1:0]            dREN,
    input  logic [NCPU-1:0]            dWEN,
    input  logic [NCPU-1:0][31:0]      daddr,
    input  logic [NCPU-1:0][31:0]      dstore,
    output logic [NCPU-1:0]            dwait,
    output logic [NCPU-1:0][31:0]      dload,
    input  logic [NCPU-1:0]            ccwrite,
    input  logic [NCPU-1:0]            cctrans,
    output logic [NCPU-1:0]            ccwait,
    output logic [NCPU-1:0]            ccinv,
    output logic [NCPU-1:0][31:0]      ccsnoopaddr,
    output logic                       ramREN,
    output logic                       ramWEN,
    output logic [31:0]                ramaddr,
    output logic [31:0]                ramstore,
    input  logic [31:0]                ramload,
    input  ramstate_t                  ramstate
);
    localparam int PW = $clog2(NCPU);
    localparam int BW = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BLOCK_WORDS - 1);

    typedef enum logic [2:0] {IDLE, IFETCH, SNOOP, WB, MEM, FIN} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] dptr_q, dptr_d, iptr_q, iptr_d;
    logic [PW-1:0] req_q, req_d, ireq_q, ireq_d, sup_q, sup_d;
    logic [BW-1:0] beat_q, beat_d;

    logic [NCPU-1:0] dreq, others_wr;
    logic            ram_acc;

    // ERROR counts as not-ACCESS: stall and hold the beat.
    assign ram_acc   = (ramstate == ACCESS);
    assign dreq      = dREN | dWEN;
    // The requester's own ccwrite is meaningless during its snoop.
    assign others_wr = ccwrite & ~(NCPU'(1) << req_q);

    // First set bit at or after ptr, wrapping. With ptr=0 this is the lowest index.
    function automatic logic [PW-1:0] rr_pick(input logic [NCPU-1:0] reqs, input logic [PW-1:0] ptr);
        logic [PW-1:0] win;
        logic          found;
        int            idx;
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < NCPU; i++) begin
            idx = (int'(ptr) + i) % NCPU;
            if (!found && reqs[idx]) begin
                win   = PW'(idx);
                found = 1'b1;
            end
        end
        return win;
    endfunction

    function automatic logic [PW-1:0] rr_next(input logic [PW-1:0] w);
        return (w == PW'(NCPU - 1)) ? '0 : w + 1'b1;
    endfunction

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            dptr_q  <= '0;
            iptr_q  <= '0;
            req_q   <= '0;
            ireq_q  <= '0;
            sup_q   <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            dptr_q  <= dptr_d;
            iptr_q  <= iptr_d;
            req_q   <= req_d;
            ireq_q  <= ireq_d;
            sup_q   <= sup_d;
            beat_q  <= beat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dptr_d  = dptr_q;
        iptr_d  = iptr_q;
        req_d   = req_q;
        ireq_d  = ireq_q;
        sup_d   = sup_q;
        beat_d  = beat_q;
        case (state_q)
            IDLE: begin
                if (|dreq) begin
                    req_d   = rr_pick(dreq, dptr_q);
                    dptr_d  = rr_next(req_d);
                    state_d = SNOOP;
                end else if (|iREN) begin
                    ireq_d  = rr_pick(iREN, iptr_q);
                    iptr_d  = rr_next(ireq_d);
                    state_d = IFETCH;
                end
            end
            IFETCH: if (ram_acc) state_d = IDLE;
            SNOOP: begin
                beat_d = '0;
                if (|others_wr) begin
                    sup_d   = rr_pick(others_wr, '0);
                    state_d = WB;
                end else begin
                    state_d = MEM;
                end
            end
            WB: if (ram_acc) begin
                if (beat_q == LAST_BEAT) begin
                    beat_d  = '0;
                    state_d = MEM;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            MEM: if (ram_acc) begin
                if (beat_q == LAST_BEAT) begin
                    beat_d  = '0;
                    state_d = FIN;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            FIN: if (cctrans[req_q]) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        iwait       = '0;
        iload       = '0;
        dwait       = '0;
        dload       = '0;
        ccwait      = '0;
        ccinv       = '0;
        ccsnoopaddr = '0;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;
        case (state_q)
            IFETCH: begin
                ramREN        = 1'b1;
                ramaddr       = iaddr[ireq_q];
                iload[ireq_q] = ramload;
                iwait[ireq_q] = !ram_acc;
            end
            SNOOP: begin
                dwait[req_q] = 1'b1;
                for (int k = 0; k < NCPU; k++) begin
                    if (PW'(k) != req_q) begin
                        ccwait[k]      = 1'b1;
                        ccsnoopaddr[k] = daddr[req_q];
                        ccinv[k]       = dWEN[req_q];
                    end
                end
            end
            WB: begin
                // Supplier flushes its dirty block; requester keeps stalling.
                ccwait[sup_q] = 1'b1;
                ramWEN        = 1'b1;
                ramaddr       = daddr[sup_q];
                ramstore      = dstore[sup_q];
                dwait[sup_q]  = !ram_acc;
                dwait[req_q]  = 1'b1;
            end
            MEM: begin
                ramREN       = dREN[req_q];
                ramWEN       = dWEN[req_q];
                ramaddr      = daddr[req_q];
                ramstore     = dstore[req_q];
                dload[req_q] = ramload;
                dwait[req_q] = !ram_acc;
            end
            FIN: dwait[req_q] = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_multicore_bus_ctrl.sv
// tb_multicore_bus_ctrl
//   Directed bench for multicore_bus_ctrl (NCPU=4, BLOCK_WORDS=2).
//   Inputs change and outputs are sampled on the falling edge; the RAM
//   returns ramaddr ^ LMASK so read data is predictable from the address.
module tb_multicore_bus_ctrl;
    import multicore_bus_ctrl_pkg::*;

    localparam int NCPU = 4;
    localparam logic [31:0] LMASK = 32'h5A5A_0000;

    logic                  CLK  = 1'b0;
    logic                  nRST = 1'b1;
    logic [NCPU-1:0]       iREN, iwait, dREN, dWEN, dwait, ccwrite, cctrans, ccwait, ccinv;
    logic [NCPU-1:0][31:0] iaddr, iload, daddr, dstore, dload, ccsnoopaddr;
    logic                  ramREN, ramWEN;
    logic [31:0]           ramaddr, ramstore, ramload;
    ramstate_t             ramstate;
    logic [465:0]          all_out;

    int vectors = 0;
    int errs    = 0;

    multicore_bus_ctrl #(.NCPU(NCPU), .BLOCK_WORDS(2)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ccwrite(ccwrite), .cctrans(cctrans), .ccwait(ccwait), .ccinv(ccinv),
        .ccsnoopaddr(ccsnoopaddr),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    assign ramload = ramaddr ^ LMASK;
    assign all_out = {iwait, iload, dwait, dload, ccwait, ccinv, ccsnoopaddr,
                      ramREN, ramWEN, ramaddr, ramstore};

    always #5 CLK = ~CLK;

    task automatic step;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic init_inputs;
        iREN = '0; dREN = '0; dWEN = '0; ccwrite = '0; cctrans = '0;
        ramstate = ACCESS;
        for (int k = 0; k < NCPU; k++) begin
            iaddr[k]  = 32'h0000_1000 + 32'(k * 16);
            daddr[k]  = 32'h0000_2000 + 32'(k * 16);
            dstore[k] = 32'hD000_0000 + 32'(k);
        end
    endtask

    task automatic test_reset;
        iREN = 4'b1111; dREN = 4'b1111;
        #1 nRST = 1'b0;
        #1;
        vectors++; if (all_out !== '0) begin errs++; $display("FAIL reset_outputs got %h want 0", all_out); end
        vectors++; if (dut.dptr_q !== 2'd0) begin errs++; $display("FAIL reset_dptr got %0d want 0", dut.dptr_q); end
        step; step;
        vectors++; if (all_out !== '0) begin errs++; $display("FAIL reset_held got %h want 0", all_out); end
        iREN = '0; dREN = '0;
        nRST = 1'b1;
        step;
        vectors++; if (all_out !== '0) begin errs++; $display("FAIL reset_idle got %h want 0", all_out); end
    endtask

    // Cores 1 and 3 request with dptr=0: core 1 first, then core 3, dptr wraps to 0.
    task automatic test_round_robin;
        dREN = 4'b1010;
        step;
        vectors++; if ({ramREN, ramWEN, dwait, ccwait, ccinv} !== {2'b00, 4'b0010, 4'b1101, 4'b0000}) begin
            errs++; $display("FAIL rr_snoop1 got %b want %b", {ramREN, ramWEN, dwait, ccwait, ccinv}, {2'b00, 4'b0010, 4'b1101, 4'b0000}); end
        vectors++; if (ccsnoopaddr !== {daddr[1], daddr[1], 32'h0, daddr[1]}) begin
            errs++; $display("FAIL rr_snoopaddr1 got %h want %h", ccsnoopaddr, {daddr[1], daddr[1], 32'h0, daddr[1]}); end
        for (int b = 0; b < 2; b++) begin
            step;
            vectors++; if ({ramREN, ramWEN, dwait, ramaddr, dload[1]} !== {2'b10, 4'b0000, daddr[1], daddr[1] ^ LMASK}) begin
                errs++; $display("FAIL rr_mem1 beat %0d got %h want %h", b, {ramREN, ramWEN, dwait, ramaddr, dload[1]}, {2'b10, 4'b0000, daddr[1], daddr[1] ^ LMASK}); end
        end
        step;
        vectors++; if ({ramREN, dwait} !== {1'b0, 4'b0010}) begin errs++; $display("FAIL rr_fin1 got %b want %b", {ramREN, dwait}, {1'b0, 4'b0010}); end
        cctrans = 4'b0010;
        step;
        vectors++; if (all_out !== '0) begin errs++; $display("FAIL rr_idle1 got %h want 0", all_out); end
        cctrans = '0;
        step;
        vectors++; if ({dwait, ccwait} !== {4'b1000, 4'b0111}) begin errs++; $display("FAIL rr_snoop3 got %b want %b", {dwait, ccwait}, {4'b1000, 4'b0111}); end
        vectors++; if (ccsnoopaddr !== {32'h0, daddr[3], daddr[3], daddr[3]}) begin
            errs++; $display("FAIL rr_snoopaddr3 got %h want %h", ccsnoopaddr, {32'h0, daddr[3], daddr[3], daddr[3]}); end
        dREN = 4'b1000;
        for (int b = 0; b < 2; b++) begin
            step;
            vectors++; if ({ramREN, ramaddr, dload[3]} !== {1'b1, daddr[3], daddr[3] ^ LMASK}) begin
                errs++; $display("FAIL rr_mem3 beat %0d got %h want %h", b, {ramREN, ramaddr, dload[3]}, {1'b1, daddr[3], daddr[3] ^ LMASK}); end
        end
        step;
        vectors++; if (dwait !== 4'b1000) begin errs++; $display("FAIL rr_fin3 got %b want 1000", dwait); end
        cctrans = 4'b1000; dREN = '0;
        step;
        vectors++; if (dut.dptr_q !== 2'd0) begin errs++; $display("FAIL rr_dptr_end got %0d want 0", dut.dptr_q); end
        vectors++; if (all_out !== '0) begin errs++; $display("FAIL rr_idle3 got %h want 0", all_out); end
        cctrans = '0;
    endtask

    // Data beats instruction when both arrive together; fetch follows FIN.
    task automatic test_data_over_instr;
        iREN = 4'b0001; dREN = 4'b0100;
        step;
        vectors++; if ({dwait, ccwait, iwait, ramREN} !== {4'b0100, 4'b1011, 4'b0000, 1'b0}) begin
            errs++; $display("FAIL pri_snoop got %b want %b", {dwait, ccwait, iwait, ramREN}, {4'b0100, 4'b1011, 4'b0000, 1'b0}); end
        for (int b = 0; b < 2; b++) begin
            step;
            vectors++; if ({ramREN, ramaddr} !== {1'b1, daddr[2]}) begin
                errs++; $display("FAIL pri_mem beat %0d got %h want %h", b, {ramREN, ramaddr}, {1'b1, daddr[2]}); end
        end
        step;
        vectors++; if (dwait !== 4'b0100) begin errs++; $display("FAIL pri_fin got %b want 0100", dwait); end
        cctrans = 4'b0100; dREN = '0;
        step;
        vectors++; if (all_out !== '0) begin errs++; $display("FAIL pri_idle got %h want 0", all_out); end
        cctrans = '0;
        step;
        ramstate = BUSY; #1;
        vectors++; if ({ramREN, ramaddr, iwait} !== {1'b1, iaddr[0], 4'b0001}) begin
            errs++; $display("FAIL ifetch_busy got %h want %h", {ramREN, ramaddr, iwait}, {1'b1, iaddr[0], 4'b0001}); end
        ramstate = ACCESS; #1;
        vectors++; if ({iwait, iload[0]} !== {4'b0000, iaddr[0] ^ LMASK}) begin
            errs++; $display("FAIL ifetch_access got %h want %h", {iwait, iload[0]}, {4'b0000, iaddr[0] ^ LMASK}); end
        iREN = '0;
        step;
        vectors++; if (all_out !== '0) begin errs++; $display("FAIL ifetch_done got %h want 0", all_out); end
    endtask

    // BusRdX from core 0, core 2 dirty: invalidate others, 2 WB beats, 2 MEM beats.
    task automatic test_rdx_writeback;
        dWEN = 4'b0001;
        step;
        vectors++; if ({dwait, ccwait, ccinv} !== {4'b0001, 4'b1110, 4'b1110}) begin
            errs++; $display("FAIL rdx_snoop got %b want %b", {dwait, ccwait, ccinv}, {4'b0001, 4'b1110, 4'b1110}); end
        ccwrite = 4'b0100;
        for (int b = 0; b < 2; b++) begin
            step;
            ccwrite = '0;
            vectors++; if ({ramREN, ramWEN, ccwait, dwait, ramaddr, ramstore} !== {2'b01, 4'b0100, 4'b0001, daddr[2], dstore[2]}) begin
                errs++; $display("FAIL rdx_wb beat %0d got %h want %h", b, {ramREN, ramWEN, ccwait, dwait, ramaddr, ramstore}, {2'b01, 4'b0100, 4'b0001, daddr[2], dstore[2]}); end
        end
        for (int b = 0; b < 2; b++) begin
            step;
            vectors++; if ({ramREN, ramWEN, ccwait, dwait, ramaddr, ramstore} !== {2'b01, 4'b0000, 4'b0000, daddr[0], dstore[0]}) begin
                errs++; $display("FAIL rdx_mem beat %0d got %h want %h", b, {ramREN, ramWEN, ccwait, dwait, ramaddr, ramstore}, {2'b01, 4'b0000, 4'b0000, daddr[0], dstore[0]}); end
        end
        step;
        cctrans = 4'b0100;
        vectors++; if ({ramWEN, dwait} !== {1'b0, 4'b0001}) begin errs++; $display("FAIL rdx_fin got %b want %b", {ramWEN, dwait}, {1'b0, 4'b0001}); end
        step;
        vectors++; if (dwait !== 4'b0001) begin errs++; $display("FAIL rdx_fin_hold got %b want 0001", dwait); end
        cctrans = 4'b0001; dWEN = '0;
        step;
        vectors++; if (all_out !== '0) begin errs++; $display("FAIL rdx_idle got %h want 0", all_out); end
        cctrans = '0;
    endtask

    // Cores 1 and 3 (and the requester itself) assert ccwrite: only core 1 supplies.
    task automatic test_two_dirty;
        dREN = 4'b0001;
        step;
        vectors++; if (dwait !== 4'b0001) begin errs++; $display("FAIL dirty2_snoop got %b want 0001", dwait); end
        ccwrite = 4'b1011;
        for (int b = 0; b < 2; b++) begin
            step;
            ccwrite = '0;
            vectors++; if ({ramWEN, ccwait, ramaddr, ramstore} !== {1'b1, 4'b0010, daddr[1], dstore[1]}) begin
                errs++; $display("FAIL dirty2_wb beat %0d got %h want %h", b, {ramWEN, ccwait, ramaddr, ramstore}, {1'b1, 4'b0010, daddr[1], dstore[1]}); end
        end
        for (int b = 0; b < 2; b++) begin
            step;
            vectors++; if ({ramREN, ramWEN, ramaddr, dload[0]} !== {2'b10, daddr[0], daddr[0] ^ LMASK}) begin
                errs++; $display("FAIL dirty2_mem beat %0d got %h want %h", b, {ramREN, ramWEN, ramaddr, dload[0]}, {2'b10, daddr[0], daddr[0] ^ LMASK}); end
        end
        step;
        cctrans = 4'b0001; dREN = '0;
        step;
        vectors++; if (all_out !== '0) begin errs++; $display("FAIL dirty2_idle got %h want 0", all_out); end
        cctrans = '0;
    endtask

    // Three stall cycles (BUSY/ERROR) before every ACCESS: MEM lasts 8 cycles.
    task automatic test_mem_stall;
        dREN = 4'b0100;
        step;
        vectors++; if (dwait !== 4'b0100) begin errs++; $display("FAIL stall_snoop got %b want 0100", dwait); end
        for (int b = 0; b < 2; b++) begin
            for (int c = 0; c < 4; c++) begin
                step;
                ramstate = (c == 3) ? ACCESS : ((c == 1) ? ERROR : BUSY);
                #1;
                vectors++; if ({ramREN, ramaddr, dwait} !== {1'b1, daddr[2], (c == 3) ? 4'b0000 : 4'b0100}) begin
                    errs++; $display("FAIL stall_mem beat %0d cyc %0d got %h want %h", b, c, {ramREN, ramaddr, dwait}, {1'b1, daddr[2], (c == 3) ? 4'b0000 : 4'b0100}); end
            end
        end
        step;
        vectors++; if ({ramREN, dwait} !== {1'b0, 4'b0100}) begin errs++; $display("FAIL stall_fin got %b want %b", {ramREN, dwait}, {1'b0, 4'b0100}); end
        cctrans = 4'b0100; dREN = '0;
        step;
        cctrans = '0;
    endtask

    // Reset during the second WB beat drops everything at once.
    task automatic test_reset_mid_wb;
        dWEN = 4'b0010;
        step;
        ccwrite = 4'b0001;
        step;
        ccwrite = '0;
        vectors++; if ({ramWEN, ccwait, dwait, ramaddr} !== {1'b1, 4'b0001, 4'b0010, daddr[0]}) begin
            errs++; $display("FAIL rst_wb0 got %h want %h", {ramWEN, ccwait, dwait, ramaddr}, {1'b1, 4'b0001, 4'b0010, daddr[0]}); end
        step;
        nRST = 1'b0;
        #1;
        vectors++; if (all_out !== '0) begin errs++; $display("FAIL rst_wb1_outputs got %h want 0", all_out); end
        vectors++; if (dut.dptr_q !== 2'd0) begin errs++; $display("FAIL rst_wb1_dptr got %0d want 0", dut.dptr_q); end
        dWEN = '0;
        step;
        nRST = 1'b1;
        step;
        vectors++; if (all_out !== '0) begin errs++; $display("FAIL rst_release got %h want 0", all_out); end
        // First grant after reset starts from core 0 and completes normally.
        dREN = 4'b0001;
        step;
        vectors++; if ({dwait, ccwait} !== {4'b0001, 4'b1110}) begin errs++; $display("FAIL rst_regrant got %b want %b", {dwait, ccwait}, {4'b0001, 4'b1110}); end
        step; step; step;
        vectors++; if ({ramREN, dwait} !== {1'b0, 4'b0001}) begin errs++; $display("FAIL rst_regrant_fin got %b want %b", {ramREN, dwait}, {1'b0, 4'b0001}); end
        cctrans = 4'b0001; dREN = '0;
        step;
        cctrans = '0;
    endtask

    // All cores request continuously: grants rotate 1,2,3,0 from dptr=1.
    task automatic test_back_to_back;
        logic [NCPU-1:0] exp_w;
        dREN = 4'b1111;
        for (int t = 0; t < NCPU; t++) begin
            exp_w = 4'b0001 << ((1 + t) % NCPU);
            step;
            vectors++; if ({dwait, ccwait} !== {exp_w, ~exp_w}) begin
                errs++; $display("FAIL b2b_grant %0d got %b want %b", t, {dwait, ccwait}, {exp_w, ~exp_w}); end
            step; step; step;
            cctrans = exp_w;
            if (t == NCPU - 1) dREN = '0;
            step;
            cctrans = '0;
        end
        vectors++; if (all_out !== '0) begin errs++; $display("FAIL b2b_idle got %h want 0", all_out); end
    endtask

    initial begin
        init_inputs;
        test_reset;
        test_round_robin;
        test_data_over_instr;
        test_rdx_writeback;
        test_two_dirty;
        test_mem_stall;
        test_reset_mid_wb;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
